// File: rtl/wb_csr_ctrl_pkg.sv
// Shared encodings for the write-back CSR controller.
// Contents: CSR op codes, CSR indices, exception codes and FSM states.
package wb_csr_ctrl_pkg;

  typedef enum logic [2:0] {
    OP_NONE = 3'd0,
    OP_RD   = 3'd1,
    OP_WR   = 3'd2,
    OP_XCHG = 3'd3,
    OP_ERTN = 3'd4
  } csr_op_e;

  localparam logic [13:0] CSR_CRMD   = 14'h000;
  localparam logic [13:0] CSR_ECFG   = 14'h004;
  localparam logic [13:0] CSR_ESTAT  = 14'h005;
  localparam logic [13:0] CSR_ERA    = 14'h006;
  localparam logic [13:0] CSR_EENTRY = 14'h00c;

  localparam logic [5:0] ECODE_INT = 6'h00;
  localparam logic [5:0] ECODE_ADE = 6'h08;
  localparam logic [5:0] ECODE_ALE = 6'h09;
  localparam logic [5:0] ECODE_SYS = 6'h0b;
  localparam logic [5:0] ECODE_BRK = 6'h0c;
  localparam logic [5:0] ECODE_INE = 6'h0d;

  typedef enum logic {
    ST_RUN      = 1'b0,
    ST_REDIRECT = 1'b1
  } ws_state_e;

endpackage

// File: rtl/wb_csr_ctrl.sv
// Write-back stage: commits one instruction per cycle to the GPR/CSR files and
// raises a held fetch redirect. Define WB_CSR_INT_EN to let has_int take interrupts.
module wb_csr_ctrl
  import wb_csr_ctrl_pkg::*;
#(
  parameter int DW        = 32,
  parameter int CSR_NUM_W = 14
) (
  input  logic                 clk,
  input  logic                 resetn,
  input  logic                 ms_valid,
  output logic                 ws_allowin,
  input  logic [DW-1:0]        ms_pc,
  input  logic [2:0]           ms_csr_op,
  input  logic [CSR_NUM_W-1:0] ms_csr_num,
  input  logic [DW-1:0]        ms_rj_val,
  input  logic [DW-1:0]        ms_rd_val,
  input  logic                 ms_ex,
  input  logic [5:0]           ms_ecode,
  input  logic [8:0]           ms_esubcode,
  input  logic [DW-1:0]        ms_vaddr,
  input  logic                 ms_rf_we,
  input  logic [4:0]           ms_rf_waddr,
  input  logic [DW-1:0]        ms_rf_wdata,
  output logic                 rf_we,
  output logic [4:0]           rf_waddr,
  output logic [DW-1:0]        rf_wdata,
  output logic                 csr_re,
  output logic [CSR_NUM_W-1:0] csr_num,
  input  logic [DW-1:0]        csr_rvalue,
  output logic                 csr_we,
  output logic [DW-1:0]        csr_wmask,
  output logic [DW-1:0]        csr_wvalue,
  input  logic                 has_int,
  output logic                 wb_ex,
  output logic                 ertn_flush,
  output logic [DW-1:0]        wb_pc,
  output logic [DW-1:0]        wb_vaddr,
  output logic [5:0]           wb_ecode,
  output logic [8:0]           wb_esubcode,
  input  logic [DW-1:0]        csr_eentry_data,
  input  logic [DW-1:0]        csr_era_pc,
  output logic                 redirect_valid,
  output logic [DW-1:0]        redirect_target,
  input  logic                 redirect_ready
);

  ws_state_e            r_state;
  logic                 r_ws_valid;
  logic [DW-1:0]        r_pc;
  logic [2:0]           r_op;
  logic [CSR_NUM_W-1:0] r_csr_num;
  logic [DW-1:0]        r_rj_val;
  logic [DW-1:0]        r_rd_val;
  logic                 r_ex;
  logic [5:0]           r_ecode;
  logic [8:0]           r_esubcode;
  logic [DW-1:0]        r_vaddr;
  logic                 r_rf_we;
  logic [4:0]           r_rf_waddr;
  logic [DW-1:0]        r_rf_wdata;
  logic                 r_redirect_valid;
  logic [DW-1:0]        r_redirect_target;

  logic                 w_int_take;
  logic                 w_final_ex;
  logic                 w_commit;
  logic                 w_is_csr;
  logic                 w_csr_wr;
  logic                 w_refetch;
  logic                 w_redirect;
  logic [DW-1:0]        w_target;

`ifdef WB_CSR_INT_EN
  assign w_int_take = has_int;
`else
  logic w_unused_has_int;
  assign w_unused_has_int = has_int;
  assign w_int_take       = 1'b0;
`endif

  assign w_commit   = r_ws_valid && (r_state == ST_RUN);
  assign w_final_ex = w_int_take || r_ex;
  assign w_is_csr   = (r_op == OP_RD) || (r_op == OP_WR) || (r_op == OP_XCHG);
  assign w_csr_wr   = (r_op == OP_WR) || (r_op == OP_XCHG);

  assign ws_allowin  = 1'b1;
  assign wb_ex       = w_commit && w_final_ex;
  assign wb_pc       = r_pc;
  assign wb_vaddr    = r_vaddr;
  assign wb_ecode    = w_int_take ? ECODE_INT : r_ecode;
  assign wb_esubcode = w_int_take ? 9'd0 : r_esubcode;

  assign csr_re     = r_ws_valid && w_is_csr;
  assign csr_num    = r_csr_num;
  assign csr_we     = w_commit && !w_final_ex && w_csr_wr;
  assign csr_wmask  = (r_op == OP_WR) ? '1 : r_rj_val;
  assign csr_wvalue = r_rd_val;

  assign rf_we      = w_commit && !w_final_ex && r_rf_we;
  assign rf_waddr   = r_rf_waddr;
  assign rf_wdata   = w_is_csr ? csr_rvalue : r_rf_wdata;
  assign ertn_flush = w_commit && !w_final_ex && (r_op == OP_ERTN);

  // Writes to mode/config/status CSRs can change fetch behaviour, so refetch.
  assign w_refetch = csr_we && ((r_csr_num == CSR_NUM_W'(CSR_CRMD)) ||
                                (r_csr_num == CSR_NUM_W'(CSR_ECFG)) ||
                                (r_csr_num == CSR_NUM_W'(CSR_ESTAT)));
  assign w_redirect = wb_ex || ertn_flush || w_refetch;
  assign w_target   = wb_ex      ? csr_eentry_data :
                      ertn_flush ? csr_era_pc      : r_pc + DW'(4);

  assign redirect_valid  = r_redirect_valid;
  assign redirect_target = r_redirect_target;

  always_ff @(posedge clk or negedge resetn) begin
    if (!resetn) begin
      r_state           <= ST_RUN;
      r_redirect_valid  <= 1'b0;
      r_redirect_target <= '0;
    end else begin
      case (r_state)
        ST_RUN: begin
          if (w_commit && w_redirect) begin
            r_state           <= ST_REDIRECT;
            r_redirect_valid  <= 1'b1;
            r_redirect_target <= w_target;
          end
        end
        ST_REDIRECT: begin
          if (redirect_ready) begin
            r_state          <= ST_RUN;
            r_redirect_valid <= 1'b0;
          end
        end
        default: begin
          r_state          <= ST_RUN;
          r_redirect_valid <= 1'b0;
        end
      endcase
    end
  end

  // Wrong-path instructions arriving while a redirect is pending are dropped.
  always_ff @(posedge clk or negedge resetn) begin
    if (!resetn) begin
      r_ws_valid <= 1'b0;
      r_pc       <= '0;
      r_op       <= '0;
      r_csr_num  <= '0;
      r_rj_val   <= '0;
      r_rd_val   <= '0;
      r_ex       <= 1'b0;
      r_ecode    <= '0;
      r_esubcode <= '0;
      r_vaddr    <= '0;
      r_rf_we    <= 1'b0;
      r_rf_waddr <= '0;
      r_rf_wdata <= '0;
    end else if (r_state == ST_RUN) begin
      r_ws_valid <= ms_valid;
      if (ms_valid) begin
        r_pc       <= ms_pc;
        r_op       <= ms_csr_op;
        r_csr_num  <= ms_csr_num;
        r_rj_val   <= ms_rj_val;
        r_rd_val   <= ms_rd_val;
        r_ex       <= ms_ex;
        r_ecode    <= ms_ecode;
        r_esubcode <= ms_esubcode;
        r_vaddr    <= ms_vaddr;
        r_rf_we    <= ms_rf_we;
        r_rf_waddr <= ms_rf_waddr;
        r_rf_wdata <= ms_rf_wdata;
      end
    end else begin
      r_ws_valid <= 1'b0;
    end
  end

endmodule

// File: tb/tb_wb_csr_ctrl.sv
// Self-checking bench for wb_csr_ctrl: directed scenarios plus randomized
// instructions compared against a behavioural commit model.
module tb_wb_csr_ctrl;

  logic        clk = 1'b0;
  logic        resetn;
  logic        ms_valid;
  logic        ws_allowin;
  logic [31:0] ms_pc;
  logic [2:0]  ms_csr_op;
  logic [13:0] ms_csr_num;
  logic [31:0] ms_rj_val, ms_rd_val;
  logic        ms_ex;
  logic [5:0]  ms_ecode;
  logic [8:0]  ms_esubcode;
  logic [31:0] ms_vaddr;
  logic        ms_rf_we;
  logic [4:0]  ms_rf_waddr;
  logic [31:0] ms_rf_wdata;
  logic        rf_we;
  logic [4:0]  rf_waddr;
  logic [31:0] rf_wdata;
  logic        csr_re;
  logic [13:0] csr_num;
  logic [31:0] csr_rvalue;
  logic        csr_we;
  logic [31:0] csr_wmask, csr_wvalue;
  logic        has_int;
  logic        wb_ex, ertn_flush;
  logic [31:0] wb_pc, wb_vaddr;
  logic [5:0]  wb_ecode;
  logic [8:0]  wb_esubcode;
  logic [31:0] csr_eentry_data, csr_era_pc;
  logic        redirect_valid;
  logic [31:0] redirect_target;
  logic        redirect_ready;

  int n_chk  = 0;
  int n_fail = 0;

  typedef struct {
    logic [2:0]  op;
    logic [13:0] num;
    logic [31:0] pc, rj, rd, vaddr, rfwd, rval, eentry, era;
    logic        ex, hint, rfwe;
    logic [5:0]  ecode;
    logic [8:0]  esub;
    logic [4:0]  waddr;
  } txn_t;

  wb_csr_ctrl #(.DW(32), .CSR_NUM_W(14)) dut (
    .clk(clk), .resetn(resetn), .ms_valid(ms_valid), .ws_allowin(ws_allowin),
    .ms_pc(ms_pc), .ms_csr_op(ms_csr_op), .ms_csr_num(ms_csr_num),
    .ms_rj_val(ms_rj_val), .ms_rd_val(ms_rd_val), .ms_ex(ms_ex),
    .ms_ecode(ms_ecode), .ms_esubcode(ms_esubcode), .ms_vaddr(ms_vaddr),
    .ms_rf_we(ms_rf_we), .ms_rf_waddr(ms_rf_waddr), .ms_rf_wdata(ms_rf_wdata),
    .rf_we(rf_we), .rf_waddr(rf_waddr), .rf_wdata(rf_wdata),
    .csr_re(csr_re), .csr_num(csr_num), .csr_rvalue(csr_rvalue),
    .csr_we(csr_we), .csr_wmask(csr_wmask), .csr_wvalue(csr_wvalue),
    .has_int(has_int), .wb_ex(wb_ex), .ertn_flush(ertn_flush),
    .wb_pc(wb_pc), .wb_vaddr(wb_vaddr), .wb_ecode(wb_ecode),
    .wb_esubcode(wb_esubcode), .csr_eentry_data(csr_eentry_data),
    .csr_era_pc(csr_era_pc), .redirect_valid(redirect_valid),
    .redirect_target(redirect_target), .redirect_ready(redirect_ready)
  );

  always #5 clk = ~clk;

  function automatic txn_t blank_txn();
    txn_t t;
    t.op = 3'd0; t.num = 14'h0; t.pc = 32'h1C000000; t.rj = '0; t.rd = '0;
    t.vaddr = '0; t.rfwd = '0; t.rval = '0; t.eentry = '0; t.era = '0;
    t.ex = 1'b0; t.hint = 1'b0; t.rfwe = 1'b0; t.ecode = '0; t.esub = '0;
    t.waddr = '0;
    return t;
  endfunction

  function automatic txn_t rand_txn();
    txn_t t;
    logic [13:0] nums [6];
    nums = '{14'h000, 14'h004, 14'h005, 14'h006, 14'h030, 14'h00c};
    t.op     = 3'($urandom_range(0, 4));
    t.num    = ($urandom_range(0, 5) == 0) ? 14'($urandom) : nums[$urandom_range(0, 5)];
    t.pc     = {$urandom} & 32'hFFFF_FFFC;
    if ($urandom_range(0, 9) == 0) t.pc = 32'hFFFF_FFFC;
    t.rj     = $urandom;
    t.rd     = $urandom;
    t.vaddr  = $urandom;
    t.rfwd   = $urandom;
    t.rval   = $urandom;
    t.eentry = $urandom;
    t.era    = $urandom;
    t.ex     = ($urandom_range(0, 4) == 0);
    t.hint   = ($urandom_range(0, 4) == 0);
    t.rfwe   = 1'($urandom);
    t.ecode  = 6'($urandom);
    t.esub   = 9'($urandom);
    t.waddr  = 5'($urandom);
    return t;
  endfunction

  task automatic idle_inputs();
    ms_valid = 0; ms_pc = '0; ms_csr_op = '0; ms_csr_num = '0; ms_rj_val = '0;
    ms_rd_val = '0; ms_ex = 0; ms_ecode = '0; ms_esubcode = '0; ms_vaddr = '0;
    ms_rf_we = 0; ms_rf_waddr = '0; ms_rf_wdata = '0; csr_rvalue = '0;
    has_int = 0; csr_eentry_data = '0; csr_era_pc = '0; redirect_ready = 0;
  endtask

  task automatic drive_junk();
    ms_valid = 1; ms_csr_op = 3'd2; ms_csr_num = 14'h000; ms_ex = 0;
    ms_rf_we = 1; ms_rd_val = $urandom; ms_pc = $urandom;
  endtask

  // Issues one instruction, checks its single commit cycle against the model,
  // then walks any redirect while keeping redirect_ready low for 'hold' cycles.
  task automatic run_txn(input txn_t t, input int hold, input logic rdy_commit,
                         output int hi);
    logic        int_on, fex, e_re, e_we, e_rfwe, e_ertn, e_redir;
    logic [5:0]  e_ecode;
    logic [8:0]  e_esub;
    logic [31:0] e_mask, e_rfwd, e_tgt;
`ifdef WB_CSR_INT_EN
    int_on = 1'b1;
`else
    int_on = 1'b0;
`endif
    fex     = (int_on && t.hint) || t.ex;
    e_ecode = (int_on && t.hint) ? 6'h00 : t.ecode;
    e_esub  = (int_on && t.hint) ? 9'h0 : t.esub;
    e_re    = (t.op >= 3'd1) && (t.op <= 3'd3);
    e_we    = !fex && (t.op == 3'd2 || t.op == 3'd3);
    e_mask  = (t.op == 3'd2) ? 32'hFFFF_FFFF : t.rj;
    e_rfwe  = !fex && t.rfwe;
    e_rfwd  = e_re ? t.rval : t.rfwd;
    e_ertn  = !fex && (t.op == 3'd4);
    e_redir = fex || e_ertn || (e_we && (t.num == 14'h0 || t.num == 14'h4 || t.num == 14'h5));
    e_tgt   = fex ? t.eentry : (e_ertn ? t.era : 32'(64'(t.pc) + 64'd4));
    hi = 0;

    ms_valid = 1; ms_pc = t.pc; ms_csr_op = t.op; ms_csr_num = t.num;
    ms_rj_val = t.rj; ms_rd_val = t.rd; ms_ex = t.ex; ms_ecode = t.ecode;
    ms_esubcode = t.esub; ms_vaddr = t.vaddr; ms_rf_we = t.rfwe;
    ms_rf_waddr = t.waddr; ms_rf_wdata = t.rfwd;
    @(posedge clk); #1;
    ms_valid = 0; has_int = t.hint; csr_rvalue = t.rval;
    csr_eentry_data = t.eentry; csr_era_pc = t.era; redirect_ready = rdy_commit;
    #1;
    n_chk++; if (wb_ex !== fex) begin n_fail++; $display("FAIL wb_ex got %0b exp %0b pc %h", wb_ex, fex, t.pc); end
    n_chk++; if (wb_pc !== t.pc) begin n_fail++; $display("FAIL wb_pc got %h exp %h", wb_pc, t.pc); end
    if (fex) begin
      n_chk++; if (wb_ecode !== e_ecode) begin n_fail++; $display("FAIL wb_ecode got %h exp %h", wb_ecode, e_ecode); end
      n_chk++; if (wb_esubcode !== e_esub) begin n_fail++; $display("FAIL wb_esubcode got %h exp %h", wb_esubcode, e_esub); end
      n_chk++; if (wb_vaddr !== t.vaddr) begin n_fail++; $display("FAIL wb_vaddr got %h exp %h", wb_vaddr, t.vaddr); end
    end
    n_chk++; if (csr_re !== e_re) begin n_fail++; $display("FAIL csr_re got %0b exp %0b", csr_re, e_re); end
    n_chk++; if (csr_num !== t.num) begin n_fail++; $display("FAIL csr_num got %h exp %h", csr_num, t.num); end
    n_chk++; if (csr_we !== e_we) begin n_fail++; $display("FAIL csr_we got %0b exp %0b", csr_we, e_we); end
    if (e_we) begin
      n_chk++; if (csr_wmask !== e_mask) begin n_fail++; $display("FAIL csr_wmask got %h exp %h", csr_wmask, e_mask); end
      n_chk++; if (csr_wvalue !== t.rd) begin n_fail++; $display("FAIL csr_wvalue got %h exp %h", csr_wvalue, t.rd); end
    end
    n_chk++; if (rf_we !== e_rfwe) begin n_fail++; $display("FAIL rf_we got %0b exp %0b", rf_we, e_rfwe); end
    if (e_rfwe) begin
      n_chk++; if (rf_waddr !== t.waddr) begin n_fail++; $display("FAIL rf_waddr got %h exp %h", rf_waddr, t.waddr); end
      n_chk++; if (rf_wdata !== e_rfwd) begin n_fail++; $display("FAIL rf_wdata got %h exp %h", rf_wdata, e_rfwd); end
    end
    n_chk++; if (ertn_flush !== e_ertn) begin n_fail++; $display("FAIL ertn_flush got %0b exp %0b", ertn_flush, e_ertn); end
    n_chk++; if (redirect_valid !== 1'b0) begin n_fail++; $display("FAIL redirect_valid_commit got %0b exp 0", redirect_valid); end

    @(posedge clk); #1;
    redirect_ready = 0; has_int = 0;
    if (e_redir) begin
      for (int i = 0; i <= hold; i++) begin
        drive_junk();
        redirect_ready = (i == hold);
        #1;
        if (redirect_valid === 1'b1) hi++;
        n_chk++; if (redirect_valid !== 1'b1) begin n_fail++; $display("FAIL redirect_valid_held got %0b exp 1 cyc %0d", redirect_valid, i); end
        n_chk++; if (redirect_target !== e_tgt) begin n_fail++; $display("FAIL redirect_target got %h exp %h", redirect_target, e_tgt); end
        n_chk++; if ({rf_we, csr_re, csr_we, wb_ex, ertn_flush} !== 5'b0) begin n_fail++; $display("FAIL strobes_in_redirect got %b exp 00000", {rf_we, csr_re, csr_we, wb_ex, ertn_flush}); end
        @(posedge clk); #1;
      end
      ms_valid = 0; redirect_ready = 0;
      #1;
      n_chk++; if (redirect_valid !== 1'b0) begin n_fail++; $display("FAIL redirect_release got %0b exp 0", redirect_valid); end
    end else begin
      #1;
      n_chk++; if (redirect_valid !== 1'b0) begin n_fail++; $display("FAIL redirect_spurious got %0b exp 0", redirect_valid); end
    end
    n_chk++; if ({rf_we, csr_re, csr_we, wb_ex, ertn_flush} !== 5'b0) begin n_fail++; $display("FAIL strobes_after got %b exp 00000", {rf_we, csr_re, csr_we, wb_ex, ertn_flush}); end
  endtask

  task automatic test_reset();
    idle_inputs();
    resetn = 0;
    drive_junk();
    repeat (2) @(posedge clk);
    #1;
    n_chk++; if (redirect_valid !== 1'b0 || redirect_target !== 32'h0) begin n_fail++; $display("FAIL reset_redirect got %0b/%h exp 0/0", redirect_valid, redirect_target); end
    n_chk++; if ({rf_we, csr_re, csr_we, wb_ex, ertn_flush} !== 5'b0) begin n_fail++; $display("FAIL reset_strobes got %b exp 00000", {rf_we, csr_re, csr_we, wb_ex, ertn_flush}); end
    n_chk++; if (ws_allowin !== 1'b1) begin n_fail++; $display("FAIL ws_allowin got %0b exp 1", ws_allowin); end
    ms_valid = 0;
    resetn = 1;
    @(posedge clk); #1;
  endtask

  task automatic test_csrwr();
    txn_t t; int hi;
    t = blank_txn();
    t.op = 3'd2; t.num = 14'h030; t.rd = 32'hDEADBEEF; t.rval = 32'h11;
    t.rfwe = 1; t.waddr = 5'd7;
    run_txn(t, 0, 1'b1, hi);
    n_chk++; if (hi !== 0) begin n_fail++; $display("FAIL csrwr_no_redirect got %0d exp 0", hi); end
  endtask

  task automatic test_csrxchg_refetch();
    txn_t t; int hi;
    t = blank_txn();
    t.op = 3'd3; t.num = 14'h004; t.rj = 32'h0000_0800; t.rd = 32'hFFFF_FFFF;
    t.pc = 32'h1C000100; t.rfwe = 1; t.waddr = 5'd3; t.rval = 32'h5;
    run_txn(t, 2, 1'b0, hi);
    n_chk++; if (redirect_target !== 32'h1C000104) begin n_fail++; $display("FAIL xchg_target got %h exp 1c000104", redirect_target); end
  endtask

  task automatic test_exception();
    txn_t t; int hi;
    t = blank_txn();
    t.op = 3'd2; t.num = 14'h000; t.ex = 1; t.ecode = 6'h09; t.vaddr = 32'h1003;
    t.eentry = 32'h1C008000; t.rfwe = 1; t.pc = 32'h1C000200;
    run_txn(t, 3, 1'b0, hi);
    n_chk++; if (hi !== 4) begin n_fail++; $display("FAIL ex_hold_cycles got %0d exp 4", hi); end
    n_chk++; if (redirect_target !== 32'h1C008000) begin n_fail++; $display("FAIL ex_target got %h exp 1c008000", redirect_target); end
  endtask

  task automatic test_ertn();
    txn_t t; int hi;
    t = blank_txn();
    t.op = 3'd4; t.era = 32'h1C000440; t.pc = 32'h1C000300;
    run_txn(t, 5, 1'b0, hi);
    n_chk++; if (hi !== 6) begin n_fail++; $display("FAIL ertn_hold_cycles got %0d exp 6", hi); end
    n_chk++; if (redirect_target !== 32'h1C000440) begin n_fail++; $display("FAIL ertn_target got %h exp 1c000440", redirect_target); end
  endtask

  task automatic test_interrupt();
    txn_t t; int hi;
    t = blank_txn();
    t.op = 3'd2; t.num = 14'h030; t.rd = 32'h1234_5678; t.hint = 1;
    t.ecode = 6'h0b; t.eentry = 32'h1C00A000; t.rfwe = 1; t.waddr = 5'd9;
    run_txn(t, 1, 1'b0, hi);
  endtask

  task automatic test_reset_in_redirect();
    txn_t t; int hi;
    t = blank_txn();
    t.ex = 1; t.ecode = 6'h0c; t.eentry = 32'h1C00C000;
    ms_valid = 1; ms_pc = t.pc; ms_csr_op = '0; ms_ex = 1; ms_ecode = t.ecode;
    ms_rf_we = 0; csr_eentry_data = t.eentry;
    @(posedge clk); #1;
    ms_valid = 0;
    @(posedge clk); #1;
    n_chk++; if (redirect_valid !== 1'b1) begin n_fail++; $display("FAIL rst_pre_redirect got %0b exp 1", redirect_valid); end
    drive_junk();
    resetn = 0;
    #1;
    n_chk++; if (redirect_valid !== 1'b0 || redirect_target !== 32'h0) begin n_fail++; $display("FAIL rst_async got %0b/%h exp 0/0", redirect_valid, redirect_target); end
    n_chk++; if ({rf_we, csr_re, csr_we, wb_ex, ertn_flush} !== 5'b0) begin n_fail++; $display("FAIL rst_async_strobes got %b exp 00000", {rf_we, csr_re, csr_we, wb_ex, ertn_flush}); end
    @(posedge clk); #1;
    ms_valid = 0;
    resetn = 1;
    @(posedge clk); #1;
    t = blank_txn();
    t.op = 3'd1; t.num = 14'h030; t.rval = 32'hCAFE_0001; t.rfwe = 1; t.waddr = 5'd2;
    run_txn(t, 0, 1'b0, hi);
  endtask

  task automatic test_random();
    txn_t t; int hi;
    for (int n = 0; n < 150; n++) begin
      t = rand_txn();
      run_txn(t, $urandom_range(0, 3), 1'($urandom), hi);
    end
  endtask

  initial begin
    test_reset();
    test_csrwr();
    test_csrxchg_refetch();
    test_exception();
    test_ertn();
    test_interrupt();
    test_reset_in_redirect();
    test_random();
    $display("End of test - %0d assertions evaluated, %0d failures", n_chk, n_fail);
    $finish;
  end

endmodule
